jpeg_wrdma: RTL and testbench
=============================

// Module: jpeg_wrdma
// PURPOSE
//  Write-direction DMA for the JPEG accelerator: drains finished 32-bit words from the output
//  block RAM (written by the entropy/packer stage) and stores them to main memory as a Wishbone
//  bus master. Destination pointer auto-increments across blocks, so a whole frame's bitstream is
//  laid out contiguously. Configured and polled by the CPU through the JPEG slave window (dmaen_i).
// PARAMETERS
//  BURST_LEN  8  words written per bus tenure before one idle cycle releases cyc
//  BRAM_AW    9  output block RAM address width (word addresses)
// PORTS
//  clk_i          in   1   clock
//  rst_i          in   1   asynchronous, active-high reset
//  wb_adr_i       in   32  slave register address; [4:2] selects register
//  wb_dat_i       in   32  slave write data
//  wb_we_i        in   1   slave write strobe (qualified by dmaen_i)
//  wb_dat_o       out  32  slave read data (combinational)
//  dmaen_i        in   1   slave window select for this block
//  wbm            -    -   wishbone.master: adr, dat_o, sel, we, cyc, stb driven; ack, err, dat_i sampled
//  obram_addr     out  BRAM_AW  output RAM read address (1-cycle read latency)
//  obram_data     in   32  output RAM read data
//  blk_ready_i    in   1   1-cycle pulse: producer has blk_words_i words at obram address 0..N-1
//  blk_words_i    in   7   word count of ready block, 1..64 (0 treated as 64)
//  blk_done_o     out  1   1-cycle pulse: last word of block acked on bus; RAM may be overwritten
//  irq_o          out  1   level: set on frame-stop done or bus error, cleared by CTRL write bit3
// BEHAVIOUR
//  Registers (wb_adr_i[4:2]): 000 DST (RW, start byte address, [1:0] forced 0);
//   001 CTRL write: b0 arm, b1 abort, b2 clear err, b3 clear irq; read STATUS
//   {wcnt[15:0], 10'b0, irq, err, pend, state[2:0]}; 010 PTR (RO, next write address);
//   011 WCNT (RO, 32-bit total words acked since arm); others read 0.
//  DST writes ignored while state != IDLE. Arm loads PTR<=DST, WCNT<=0.
//  Reset: state IDLE, all regs 0; cyc/stb/we/blk_done_o/irq_o/obram_addr = 0, sel = 4'hF.
//  Master always drives sel=4'hF, we=1 while cyc; dat_o/adr registered, stable while stb high.
//  FSM: IDLE -arm-> WAITBLK; WAITBLK -(blk_ready_i or pend)-> FETCH; FETCH (obram_addr=idx)
//   -> LOAD (capture obram_data into dat_o, adr<=PTR) -> WRITE (cyc=stb=1 until ack);
//   on ack: PTR+=4, WCNT++, idx++; last word -> blk_done_o pulse next cycle, -> WAITBLK;
//   beat count==BURST_LEN -> RELEASE (cyc=0 one cycle) -> FETCH; else -> FETCH.
//   Between beats of one tenure cyc stays high, stb drops for FETCH/LOAD (2 cycles).
//  Word latency: blk_ready_i to first stb = 3 cycles (WAITBLK, FETCH, LOAD).
//  blk_ready_i while busy with a block: latched into pend (one deep) with its word count;
//   second pulse while pend already set is dropped and sets err.
//  wbm.err during WRITE: drop cyc/stb, set err and irq, -> IDLE; PTR left at failing word.
//  Abort: if in WRITE, finish current beat (wait ack/err) then IDLE; otherwise IDLE next
//   cycle; pend cleared; no blk_done_o for partial block; irq set.
//  Arm while not IDLE ignored. PTR wraps modulo 2^32. WCNT saturates at 32'hFFFF_FFFF.
//  Asynchronous rst_i mid-tenure: cyc/stb drop immediately, all state lost.
// TESTING
//  DST=0x100, arm, blk_ready_i words=4 RAM={A,B,C,D}, ack 1-cycle -> writes A..D at
//   0x100..0x10C, blk_done_o once, PTR=0x110, WCNT=4.
//  words=0 (64), BURST_LEN=8 -> 8 tenures, cyc low exactly 1 cycle between, PTR advances 256.
//  Two blocks back-to-back (2nd pulse during first) -> pend=1, both written contiguously;
//   third pulse while pend -> err=1.
//  wbm.err on beat 3 of 5 -> cyc low next cycle, state IDLE, err=1, irq_o=1, WCNT=2.
//  Abort mid WRITE with ack delayed 5 cycles -> stb held until ack, then IDLE, no blk_done_o.
//  rst_i asserted mid-beat -> cyc/stb/irq_o 0 same cycle without clock; all registers read 0.

Source files
------------

// File: rtl/jpeg_wrdma.sv
// jpeg_wrdma: write DMA, output block RAM -> main memory via Wishbone master.
// Ports: clk_i/rst_i; wb_* slave regs (dmaen_i select); wbm_* bus master;
//   obram_* RAM read; blk_ready_i/blk_words_i in; blk_done_o, irq_o out.
module jpeg_wrdma #(
  parameter int BURST_LEN = 8,
  parameter int BRAM_AW   = 9
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  input  logic               wb_we_i,
  output logic [31:0]        wb_dat_o,
  input  logic               dmaen_i,
  output logic [31:0]        wbm_adr,
  output logic [31:0]        wbm_dat_o,
  output logic [3:0]         wbm_sel,
  output logic               wbm_we,
  output logic               wbm_cyc,
  output logic               wbm_stb,
  input  logic               wbm_ack,
  input  logic               wbm_err,
  input  logic [31:0]        wbm_dat_i,
  output logic [BRAM_AW-1:0] obram_addr,
  input  logic [31:0]        obram_data,
  input  logic               blk_ready_i,
  input  logic [6:0]         blk_words_i,
  output logic               blk_done_o,
  output logic               irq_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_FETCH = 3'd2,
    S_LOAD  = 3'd3,
    S_WRITE = 3'd4,
    S_REL   = 3'd5
  } state_t;

  state_t      state, nxt;
  logic [31:0] dst, ptr, wcnt;
  logic        err, pend, abort_q;
  logic [5:0]  pend_words, cur_words, idx;
  logic [7:0]  beat;

  logic        wr_en, dst_wr, ctl_wr;
  logic        arm, abort, clr_err, clr_irq;
  logic        last, burst_end, ack_ok;
  logic        consume, blk_drop, go_idle;
  logic        unused_ok;

  assign unused_ok = ^{wbm_dat_i, wb_adr_i[31:5],
                       wb_adr_i[1:0], blk_words_i[6]};

  assign wr_en   = dmaen_i & wb_we_i;
  assign dst_wr  = wr_en & (wb_adr_i[4:2] == 3'd0);
  assign ctl_wr  = wr_en & (wb_adr_i[4:2] == 3'd1);
  assign arm     = ctl_wr & wb_dat_i[0] & (state == S_IDLE);
  assign abort   = ctl_wr & wb_dat_i[1] & (state != S_IDLE);
  assign clr_err = ctl_wr & wb_dat_i[2];
  assign clr_irq = ctl_wr & wb_dat_i[3];

  // Word count 0 and 64 share low bits 0, so count-1 gives 63 for both.
  assign last      = (idx == (cur_words - 6'd1));
  assign burst_end = (beat == 8'(BURST_LEN - 1));
  assign ack_ok    = (state == S_WRITE) & wbm_ack & ~wbm_err;

  assign consume  = (state == S_WAIT) & (nxt == S_FETCH);
  assign blk_drop = blk_ready_i & (state != S_IDLE) & ~consume & pend;
  assign go_idle  = (state != S_IDLE) & (nxt == S_IDLE);

  assign obram_addr = {{(BRAM_AW-6){1'b0}}, idx};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (arm) nxt = S_WAIT;
      S_WAIT: begin
        if (abort)                    nxt = S_IDLE;
        else if (blk_ready_i || pend) nxt = S_FETCH;
      end
      S_FETCH: nxt = abort ? S_IDLE : S_LOAD;
      S_LOAD:  nxt = abort ? S_IDLE : S_WRITE;
      S_WRITE: begin
        if (wbm_err)              nxt = S_IDLE;
        else if (wbm_ack) begin
          if (abort_q || abort)   nxt = S_IDLE;
          else if (last)          nxt = S_WAIT;
          else if (burst_end)     nxt = S_REL;
          else                    nxt = S_FETCH;
        end
      end
      S_REL:   nxt = abort ? S_IDLE : S_FETCH;
      default: nxt = S_IDLE;
    endcase
  end

  // cyc is held through FETCH/LOAD between beats of a block (idx != 0);
  // it only falls in RELEASE, at block end, or on leaving to IDLE.
  always_comb begin
    wbm_stb = (state == S_WRITE);
    wbm_cyc = (state == S_WRITE) |
              (((state == S_FETCH) | (state == S_LOAD)) & (idx != 6'd0));
    wbm_we  = wbm_cyc;
    wbm_sel = 4'hF;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dst        <= '0;
      ptr        <= '0;
      wcnt       <= '0;
      err        <= 1'b0;
      irq_o      <= 1'b0;
      pend       <= 1'b0;
      pend_words <= '0;
      cur_words  <= '0;
      idx        <= '0;
      beat       <= '0;
      abort_q    <= 1'b0;
      blk_done_o <= 1'b0;
      wbm_adr    <= '0;
      wbm_dat_o  <= '0;
    end else begin
      blk_done_o <= 1'b0;
      if (dst_wr && state == S_IDLE)
        dst <= {wb_dat_i[31:2], 2'b00};
      if (arm) begin
        ptr  <= dst;
        wcnt <= '0;
      end
      if (state == S_LOAD) begin
        wbm_dat_o <= obram_data;
        wbm_adr   <= ptr;
      end
      if (ack_ok) begin
        ptr  <= ptr + 32'd4;
        beat <= beat + 8'd1;
        idx  <= last ? 6'd0 : idx + 6'd1;
        if (wcnt != 32'hFFFF_FFFF)
          wcnt <= wcnt + 32'd1;
        if (last && !(abort_q || abort))
          blk_done_o <= 1'b1;
      end
      if (nxt == S_REL || nxt == S_WAIT)
        beat <= '0;
      if (state == S_WRITE && abort)
        abort_q <= 1'b1;
      // Pending slot: one block may queue behind the active one.
      if (consume) begin
        if (pend) begin
          cur_words <= pend_words;
          pend      <= blk_ready_i;
          if (blk_ready_i) pend_words <= blk_words_i[5:0];
        end else begin
          cur_words <= blk_words_i[5:0];
        end
      end else if (blk_ready_i && state != S_IDLE && !pend) begin
        pend       <= 1'b1;
        pend_words <= blk_words_i[5:0];
      end
      if (clr_err) err <= 1'b0;
      if (blk_drop || (state == S_WRITE && wbm_err))
        err <= 1'b1;
      if (clr_irq) irq_o <= 1'b0;
      if (go_idle) begin
        pend    <= 1'b0;
        idx     <= '0;
        beat    <= '0;
        abort_q <= 1'b0;
        irq_o   <= 1'b1;
      end
    end
  end

  always_comb begin
    wb_dat_o = '0;
    unique case (wb_adr_i[4:2])
      3'd0:    wb_dat_o = dst;
      3'd1:    wb_dat_o = {wcnt[15:0], 10'b0, irq_o, err, pend, state};
      3'd2:    wb_dat_o = ptr;
      3'd3:    wb_dat_o = wcnt;
      default: wb_dat_o = '0;
    endcase
  end

endmodule

// File: tb/tb_jpeg_wrdma.sv
// tb_jpeg_wrdma: directed bench for the JPEG write DMA.
// Bus slave and output RAM are modelled here; expectations are hand-computed.
module tb_jpeg_wrdma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic        wb_we_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        dmaen_i = 1'b0;
  logic [31:0] wbm_adr, wbm_dat_o;
  logic [3:0]  wbm_sel;
  logic        wbm_we, wbm_cyc, wbm_stb;
  logic        s_ack = 1'b0;
  logic        s_err = 1'b0;
  logic [8:0]  obram_addr;
  logic [31:0] obram_data = '0;
  logic        blk_ready_i = 1'b0;
  logic [6:0]  blk_words_i = '0;
  logic        blk_done_o, irq_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [0:511];
  int          ack_dly = 0;
  int          err_beat = 0;
  int          wait_s = 0;
  int          resp_n = 0;
  int          cap_n = 0;
  logic [31:0] cap_adr [0:255];
  logic [31:0] cap_dat [0:255];
  int          done_cnt = 0;

  always #5 clk = ~clk;

  jpeg_wrdma #(.BURST_LEN(8), .BRAM_AW(9)) dut (
    .clk_i(clk), .rst_i(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_we_i(wb_we_i), .wb_dat_o(wb_dat_o),
    .dmaen_i(dmaen_i),
    .wbm_adr(wbm_adr), .wbm_dat_o(wbm_dat_o),
    .wbm_sel(wbm_sel), .wbm_we(wbm_we),
    .wbm_cyc(wbm_cyc), .wbm_stb(wbm_stb),
    .wbm_ack(s_ack), .wbm_err(s_err),
    .wbm_dat_i(32'h0),
    .obram_addr(obram_addr), .obram_data(obram_data),
    .blk_ready_i(blk_ready_i), .blk_words_i(blk_words_i),
    .blk_done_o(blk_done_o), .irq_o(irq_o)
  );

  always @(posedge clk) obram_data <= mem[obram_addr];

  always @(negedge clk) begin
    if (rst) begin
      s_ack  <= 1'b0;
      s_err  <= 1'b0;
      wait_s <= 0;
    end else if (s_ack || s_err) begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
    end else if (wbm_cyc && wbm_stb) begin
      if (wait_s >= ack_dly) begin
        wait_s <= 0;
        resp_n <= resp_n + 1;
        if (err_beat != 0 && resp_n + 1 == err_beat) begin
          s_err <= 1'b1;
        end else begin
          s_ack <= 1'b1;
          cap_adr[cap_n] <= wbm_adr;
          cap_dat[cap_n] <= wbm_dat_o;
          cap_n <= cap_n + 1;
        end
      end else begin
        wait_s <= wait_s + 1;
      end
    end
  end

  always @(negedge clk) if (blk_done_o) done_cnt <= done_cnt + 1;

  task automatic reg_wr(input logic [2:0] r, input logic [31:0] d);
    wb_adr_i = {27'b0, r, 2'b0};
    wb_dat_i = d;
    wb_we_i  = 1'b1;
    dmaen_i  = 1'b1;
    @(posedge clk); #1;
    wb_we_i  = 1'b0;
    dmaen_i  = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] r, output logic [31:0] d);
    wb_adr_i = {27'b0, r, 2'b0};
    #1;
    d = wb_dat_o;
  endtask

  task automatic pulse(input logic [6:0] w);
    blk_ready_i = 1'b1;
    blk_words_i = w;
    @(posedge clk); #1;
    blk_ready_i = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (done_cnt >= target) break;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (done_cnt < target) begin
      n_bad++;
      $display("FAIL wait_done: got %0d want %0d", done_cnt, target);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (wbm_cyc !== 1'b0) begin n_bad++; $display("FAIL rst_cyc: got %b want 0", wbm_cyc); end
    n_cmp++; if (wbm_stb !== 1'b0) begin n_bad++; $display("FAIL rst_stb: got %b want 0", wbm_stb); end
    n_cmp++; if (irq_o !== 1'b0) begin n_bad++; $display("FAIL rst_irq: got %b want 0", irq_o); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (wbm_sel !== 4'hF) begin n_bad++; $display("FAIL rst_sel: got %h want f", wbm_sel); end
    n_cmp++; if (wbm_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", wbm_we); end
    n_cmp++; if (blk_done_o !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", blk_done_o); end
    n_cmp++; if (obram_addr !== 9'd0) begin n_bad++; $display("FAIL rst_oaddr: got %h want 0", obram_addr); end
    for (int r = 0; r < 4; r++) begin
      reg_rd(3'(r), v);
      n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL rst_reg%0d: got %h want 0", r, v); end
    end
  endtask

  task automatic test_basic();
    logic [31:0] v;
    logic [31:0] exp_d [0:3];
    int base;
    exp_d[0] = 32'hAAAA_0001; exp_d[1] = 32'hBBBB_0002;
    exp_d[2] = 32'hCCCC_0003; exp_d[3] = 32'hDDDD_0004;
    for (int i = 0; i < 4; i++) mem[i] = exp_d[i];
    base = cap_n;
    @(posedge clk); #1;
    reg_wr(3'd0, 32'h0000_0103);
    reg_rd(3'd0, v);
    n_cmp++; if (v !== 32'h100) begin n_bad++; $display("FAIL dst_align: got %h want 100", v); end
    reg_wr(3'd1, 32'h1);
    reg_rd(3'd1, v);
    n_cmp++; if (v !== 32'h1) begin n_bad++; $display("FAIL arm_status: got %h want 1", v); end
    @(posedge clk); #1;
    pulse(7'd4);
    n_cmp++; if (wbm_stb !== 1'b0) begin n_bad++; $display("FAIL lat_fetch_stb: got %b want 0", wbm_stb); end
    @(posedge clk); #1;
    n_cmp++; if (wbm_stb !== 1'b0) begin n_bad++; $display("FAIL lat_load_stb: got %b want 0", wbm_stb); end
    @(posedge clk); #1;
    n_cmp++; if (wbm_stb !== 1'b1) begin n_bad++; $display("FAIL lat_write_stb: got %b want 1", wbm_stb); end
    n_cmp++; if ({wbm_cyc, wbm_we, wbm_sel} !== 6'b11_1111) begin n_bad++; $display("FAIL beat_ctl: got %b want 111111", {wbm_cyc, wbm_we, wbm_sel}); end
    wait_done(1, 100);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (cap_n - base !== 4) begin n_bad++; $display("FAIL basic_count: got %0d want 4", cap_n - base); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (cap_adr[base+i] !== 32'h100 + 32'(4*i)) begin n_bad++; $display("FAIL basic_adr%0d: got %h want %h", i, cap_adr[base+i], 32'h100 + 32'(4*i)); end
      n_cmp++; if (cap_dat[base+i] !== exp_d[i]) begin n_bad++; $display("FAIL basic_dat%0d: got %h want %h", i, cap_dat[base+i], exp_d[i]); end
    end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL basic_done: got %0d want 1", done_cnt); end
    reg_rd(3'd2, v);
    n_cmp++; if (v !== 32'h110) begin n_bad++; $display("FAIL basic_ptr: got %h want 110", v); end
    reg_rd(3'd3, v);
    n_cmp++; if (v !== 32'd4) begin n_bad++; $display("FAIL basic_wcnt: got %h want 4", v); end
    reg_rd(3'd1, v);
    n_cmp++; if (v !== 32'h0004_0001) begin n_bad++; $display("FAIL basic_status: got %h want 00040001", v); end
  endtask

  task automatic test_burst64();
    logic [31:0] v;
    int base, d0, rises, gaps;
    logic prev;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
    base = cap_n;
    d0 = done_cnt;
    rises = 0; gaps = 0; prev = 1'b0;
    @(posedge clk); #1;
    pulse(7'd0);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (wbm_cyc && !prev) rises++;
      if (!wbm_cyc && rises > 0 && rises < 8) gaps++;
      prev = wbm_cyc;
      if (done_cnt > d0) break;
    end
    @(posedge clk); #1;
    n_cmp++; if (done_cnt !== d0 + 1) begin n_bad++; $display("FAIL b64_done: got %0d want %0d", done_cnt, d0 + 1); end
    n_cmp++; if (cap_n - base !== 64) begin n_bad++; $display("FAIL b64_count: got %0d want 64", cap_n - base); end
    n_cmp++; if (rises !== 8) begin n_bad++; $display("FAIL b64_tenures: got %0d want 8", rises); end
    n_cmp++; if (gaps !== 7) begin n_bad++; $display("FAIL b64_gaps: got %0d want 7", gaps); end
    n_cmp++; if (cap_adr[base] !== 32'h110) begin n_bad++; $display("FAIL b64_adr0: got %h want 110", cap_adr[base]); end
    n_cmp++; if (cap_adr[base+63] !== 32'h20C) begin n_bad++; $display("FAIL b64_adr63: got %h want 20c", cap_adr[base+63]); end
    n_cmp++; if (cap_dat[base+63] !== 32'h1000_003F) begin n_bad++; $display("FAIL b64_dat63: got %h want 1000003f", cap_dat[base+63]); end
    reg_rd(3'd2, v);
    n_cmp++; if (v !== 32'h210) begin n_bad++; $display("FAIL b64_ptr: got %h want 210", v); end
    reg_rd(3'd3, v);
    n_cmp++; if (v !== 32'd68) begin n_bad++; $display("FAIL b64_wcnt: got %0d want 68", v); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    logic [31:0] exp_d [0:4];
    int base, d0;
    exp_d[0] = 32'h1000_0000; exp_d[1] = 32'h1000_0001;
    exp_d[2] = 32'h1000_0002; exp_d[3] = 32'h1000_0000;
    exp_d[4] = 32'h1000_0001;
    base = cap_n;
    d0 = done_cnt;
    @(posedge clk); #1;
    pulse(7'd3);
    pulse(7'd2);
    reg_rd(3'd1, v);
    n_cmp++; if (v[3] !== 1'b1) begin n_bad++; $display("FAIL b2b_pend: got %b want 1", v[3]); end
    pulse(7'd1);
    reg_rd(3'd1, v);
    n_cmp++; if (v[4] !== 1'b1) begin n_bad++; $display("FAIL b2b_err: got %b want 1", v[4]); end
    wait_done(d0 + 2, 200);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (cap_n - base !== 5) begin n_bad++; $display("FAIL b2b_count: got %0d want 5", cap_n - base); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (cap_adr[base+i] !== 32'h210 + 32'(4*i)) begin n_bad++; $display("FAIL b2b_adr%0d: got %h want %h", i, cap_adr[base+i], 32'h210 + 32'(4*i)); end
      n_cmp++; if (cap_dat[base+i] !== exp_d[i]) begin n_bad++; $display("FAIL b2b_dat%0d: got %h want %h", i, cap_dat[base+i], exp_d[i]); end
    end
    reg_rd(3'd2, v);
    n_cmp++; if (v !== 32'h224) begin n_bad++; $display("FAIL b2b_ptr: got %h want 224", v); end
    reg_wr(3'd1, 32'h4);
    reg_rd(3'd1, v);
    n_cmp++; if (v[4:3] !== 2'b00) begin n_bad++; $display("FAIL b2b_clr: got %b want 00", v[4:3]); end
  endtask

  task automatic test_abort();
    logic [31:0] v;
    int base, d0, k;
    ack_dly = 5;
    base = cap_n;
    d0 = done_cnt;
    @(posedge clk); #1;
    pulse(7'd4);
    for (k = 0; k < 20; k++) begin
      if (wbm_stb) break;
      @(posedge clk); #1;
    end
    reg_wr(3'd1, 32'h2);
    n_cmp++; if (wbm_stb !== 1'b1) begin n_bad++; $display("FAIL abort_hold_stb: got %b want 1", wbm_stb); end
    for (k = 0; k < 40; k++) begin
      if (!wbm_cyc) break;
      @(posedge clk); #1;
    end
    n_cmp++; if (wbm_cyc !== 1'b0) begin n_bad++; $display("FAIL abort_cyc: got %b want 0", wbm_cyc); end
    n_cmp++; if (irq_o !== 1'b1) begin n_bad++; $display("FAIL abort_irq: got %b want 1", irq_o); end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (done_cnt !== d0) begin n_bad++; $display("FAIL abort_done: got %0d want %0d", done_cnt, d0); end
    n_cmp++; if (cap_n - base !== 1) begin n_bad++; $display("FAIL abort_beats: got %0d want 1", cap_n - base); end
    reg_rd(3'd1, v);
    n_cmp++; if (v[3:0] !== 4'h0) begin n_bad++; $display("FAIL abort_state: got %h want 0", v[3:0]); end
    reg_rd(3'd2, v);
    n_cmp++; if (v !== 32'h228) begin n_bad++; $display("FAIL abort_ptr: got %h want 228", v); end
    reg_rd(3'd3, v);
    n_cmp++; if (v !== 32'd74) begin n_bad++; $display("FAIL abort_wcnt: got %0d want 74", v); end
    reg_wr(3'd1, 32'h8);
    n_cmp++; if (irq_o !== 1'b0) begin n_bad++; $display("FAIL irq_clear: got %b want 0", irq_o); end
    ack_dly = 0;
  endtask

  task automatic test_bus_err();
    logic [31:0] v;
    int base, k;
    for (int i = 0; i < 5; i++) mem[i] = 32'h5000_0000 + 32'(i);
    base = cap_n;
    err_beat = resp_n + 3;
    @(posedge clk); #1;
    reg_wr(3'd0, 32'h400);
    reg_wr(3'd1, 32'h1);
    pulse(7'd5);
    for (k = 0; k < 100; k++) begin
      if (irq_o) break;
      @(posedge clk); #1;
    end
    n_cmp++; if (irq_o !== 1'b1) begin n_bad++; $display("FAIL berr_irq: got %b want 1", irq_o); end
    n_cmp++; if ({wbm_cyc, wbm_stb} !== 2'b00) begin n_bad++; $display("FAIL berr_cyc: got %b want 00", {wbm_cyc, wbm_stb}); end
    reg_rd(3'd1, v);
    n_cmp++; if (v[4:0] !== 5'b10000) begin n_bad++; $display("FAIL berr_status: got %b want 10000", v[4:0]); end
    reg_rd(3'd3, v);
    n_cmp++; if (v !== 32'd2) begin n_bad++; $display("FAIL berr_wcnt: got %0d want 2", v); end
    reg_rd(3'd2, v);
    n_cmp++; if (v !== 32'h408) begin n_bad++; $display("FAIL berr_ptr: got %h want 408", v); end
    n_cmp++; if (cap_n - base !== 2) begin n_bad++; $display("FAIL berr_beats: got %0d want 2", cap_n - base); end
    err_beat = 0;
  endtask

  task automatic test_rst_mid();
    logic [31:0] v;
    int k;
    ack_dly = 5;
    @(posedge clk); #1;
    reg_wr(3'd1, 32'h1);
    pulse(7'd2);
    for (k = 0; k < 20; k++) begin
      if (wbm_stb) break;
      @(posedge clk); #1;
    end
    n_cmp++; if ({wbm_stb, irq_o} !== 2'b11) begin n_bad++; $display("FAIL pre_rst: got %b want 11", {wbm_stb, irq_o}); end
    #3;
    rst = 1'b1;
    #1;
    n_cmp++; if ({wbm_cyc, wbm_stb, irq_o} !== 3'b000) begin n_bad++; $display("FAIL async_rst: got %b want 000", {wbm_cyc, wbm_stb, irq_o}); end
    for (int r = 0; r < 4; r++) begin
      reg_rd(3'(r), v);
      n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL arst_reg%0d: got %h want 0", r, v); end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    ack_dly = 0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_burst64();
    test_back_to_back();
    test_abort();
    test_bus_err();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
